// File: rtl/sync_fifo_fwft.sv
// Parametrised single-clock FIFO with arbitrary depth, standard or first-word-fall-through
// read mode, almost-full/almost-empty margins, occupancy count, sticky error flags and flush.
module sync_fifo_fwft #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int FWFT      = 0,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          full,
  output logic          a_full,
  output logic          empty,
  output logic          a_empty,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          udf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_MARGIN);

  logic [DW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_vld_q, dout_vld_d;
  logic          full_q, full_d, a_full_q, a_full_d;
  logic          empty_q, empty_d, a_empty_q, a_empty_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          push_ok, pop_ok;

  always_comb begin
    pop_ok     = pop & ~empty_q;
    push_ok    = push & (~full_q | pop_ok);
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (clr) begin
      // Flush wins over any access in the same cycle; dout deliberately keeps its value.
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
      dout_vld_d = 1'b0;
    end else begin
      if (push_ok) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
      if (pop_ok)  rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
      ovf_d      = ovf_q | (push & ~push_ok);
      udf_d      = udf_q | (pop & ~pop_ok);
      dout_vld_d = pop_ok;
      if (pop_ok) dout_d = mem_q[rptr_q];
    end
    // Flags come from the next count so they line up with the registered count.
    full_d    = (count_d == CNT_FULL);
    a_full_d  = (count_d >= CNT_AF);
    empty_d   = (count_d == '0);
    a_empty_d = (count_d <= CNT_AE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      full_q     <= 1'b0;
      a_full_q   <= (CNT_AF == '0);
      empty_q    <= 1'b1;
      a_empty_q  <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      full_q     <= full_d;
      a_full_q   <= a_full_d;
      empty_q    <= empty_d;
      a_empty_q  <= a_empty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wptr_q] <= din;
  end

  assign dout     = (FWFT != 0) ? mem_q[rptr_q] : dout_q;
  assign dout_vld = (FWFT != 0) ? ~empty_q : dout_vld_q;
  assign full     = full_q;
  assign a_full   = a_full_q;
  assign empty    = empty_q;
  assign a_empty  = a_empty_q;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8-bit, 4-deep sync FIFO.
- Adds the following over that block:
  - arbitrary (non-power-of-2) depth;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - programmable almost-full / almost-empty margins;
  - occupancy count;
  - sticky overflow/underflow error flags;
  - synchronous flush.
- Sits between producer and consumer blocks on the same clock, e.g. bus-side buffering in SoC lab datapaths.

Parameters:
- DW, 8, data width in bits (>=1).
- DEPTH, 4, number of entries (>=2, any integer).
- FWFT, 0, read mode: 0 = standard (registered dout, 1-cycle read latency); 1 = first-word-fall-through.
- AF_MARGIN, 1, a_full asserts when count >= DEPTH-AF_MARGIN (0 <= AF_MARGIN < DEPTH).
- AE_MARGIN, 1, a_empty asserts when count <= AE_MARGIN (0 <= AE_MARGIN < DEPTH).
- CW, $clog2(DEPTH+1), count width (derived; do not override).

Ports:
- clk, in, 1, clock, rising edge.
- rstn, in, 1, asynchronous active-low reset.
- clr, in, 1, synchronous flush: empties FIFO, clears error flags.
- push, in, 1, write request.
- pop, in, 1, read request.
- din, in, DW, write data.
- dout, out, DW, read data.
- dout_vld, out, 1:
  - standard mode: high for one cycle, the cycle after an accepted pop;
  - FWFT mode: equals !empty.
- full, out, 1, count == DEPTH.
- a_full, out, 1, almost full.
- empty, out, 1, count == 0.
- a_empty, out, 1, almost empty.
- count, out, CW, current occupancy.
- ovf, out, 1, sticky: a push was rejected.
- udf, out, 1, sticky: a pop was rejected.

Behaviour:
- Reset (rstn low, async):
  - wptr = rptr = 0; count = 0;
  - empty = 1, a_empty = 1, full = 0; a_full = 0 (given AF_MARGIN < DEPTH);
  - dout = 0, dout_vld = 0, ovf = 0, udf = 0.
  - Storage array is not reset.
- Acceptance, evaluated on pre-edge state:
  - push_ok = push & (!full | pop_ok);
  - pop_ok = pop & !empty.
  - Push while full is accepted only when a pop is accepted in the same cycle.
  - Push+pop on an empty FIFO: push accepted, pop rejected (udf sets).
- Pointers:
  - wptr advances on push_ok; rptr advances on pop_ok.
  - Each wraps from DEPTH-1 to 0 (explicit compare, not power-of-2 masking).
- count:
  - +1 on push_ok only; -1 on pop_ok only; unchanged on both or neither.
- Flags:
  - full, empty, a_full and a_empty are registered, computed from next-count, so they are valid in the same cycle as the updated count.
- Standard mode (FWFT=0):
  - On pop_ok, dout <= mem[rptr] at that edge; dout_vld = 1 for the following cycle.
  - dout holds its last value otherwise.
- FWFT mode (FWFT=1):
  - dout = mem[rptr] whenever !empty; pop_ok consumes the head, and the next entry appears after that edge.
  - Push into an empty FIFO: empty drops and data is on dout the cycle after the push edge.
  - When empty, dout is don't-care; the bench must not check it.
- Errors:
  - ovf sets on push & !push_ok; udf sets on pop & !pop_ok.
  - Both hold until clr or reset.
  - A rejected access changes no pointer, no count and no data.
- clr:
  - Synchronous, highest priority: pointers and count go to 0, ovf/udf go to 0, dout_vld goes to 0; push/pop in the same cycle are ignored.
  - dout keeps its value.
- Reset mid-operation:
  - All state is discarded immediately; the first push after rstn rises is accepted normally.

Test Plan:
- DEPTH=4, FWFT=0, reset then push 0x10,0x11,0x12,0x13 on consecutive cycles:
  - count goes 1,2,3,4; a_full at count=3; full at count=4; empty clears after the first push; no ovf.
- Continue with a pop every other cycle:
  - dout = 0x10,0x11,0x12,0x13, each with dout_vld the cycle after the pop;
  - a_empty at count<=1; empty after the fourth pop; udf stays 0.
- Full FIFO, push 0x20 with no pop:
  - rejected, ovf = 1, count stays 4.
- Full FIFO, push 0x20 with pop in the same cycle:
  - both accepted, count stays 4; 0x20 is read out fifth.
- Empty FIFO, pop alone:
  - udf = 1, count stays 0.
- Then clr:
  - ovf = 0, udf = 0, count = 0, empty = 1.
- DEPTH=5, FWFT=1: push 0x30..0x34, pop 3, push 0x35..0x37 (exercises wrap):
  - dout shows 0x30 one cycle after the first push;
  - pops yield 0x30..0x37 in order; full at 5 entries.
- Assert rstn low mid-stream with count=3:
  - count = 0, empty = 1, dout_vld = 0 immediately;
  - after release, push 0x40 then pop returns 0x40.
